sync_fifo_flex: RTL and testbench

SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_mem.sv | 25 ++
 rtl/sync_fifo_flex.sv | 96 +++++++++
 tb/tb_sync_fifo_flex.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared width helpers and read-mode encoding for the flexible synchronous FIFO.
package fifo_pkg;

  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } rd_mode_e;

  // One extra pointer bit separates "full" from "empty" when the pointers have lapped.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one combinational read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing it would force a flop-based implementation and
  // the occupancy logic already guarantees stale words are never presented as valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO with standard or first-word-fall-through read, threshold flags and sticky errors.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  input  logic                                wr_en,
  input  logic [DATA_WIDTH-1:0]               din,
  input  logic                                rd_en,
  output logic [DATA_WIDTH-1:0]               dout,
  output logic                                full,
  output logic                                empty,
  output logic                                almost_full,
  output logic                                almost_empty,
  output logic [fifo_pkg::cnt_w(DEPTH)-1:0]   count,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = fifo_pkg::ptr_w(DEPTH);
  localparam int CW = fifo_pkg::cnt_w(DEPTH);
  localparam fifo_pkg::rd_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;
  localparam logic [CW-1:0] AF_CMP = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CMP = CW'(AE_LEVEL);

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rd_data, dout_q;
  logic                  armed;
  logic                  wr_fire, rd_fire;

  // Flags come straight from the registered pointers, so they change only after an edge.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);

  assign count        = cnt;
  assign almost_full  = (cnt >= AF_CMP);
  assign almost_empty = (cnt <= AE_CMP);

  // The first edge after reset release only arms the FIFO; nothing is accepted on it.
  assign wr_fire = armed && !clr && wr_en && !full;
  assign rd_fire = armed && !clr && rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      dout_q    <= '0;
      armed     <= 1'b0;
    end else if (!armed) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      armed <= 1'b1;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + PW'(1);
      if (wr_fire && !rd_fire)      cnt <= cnt + CW'(1);
      else if (rd_fire && !wr_fire) cnt <= cnt - CW'(1);
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
      if (rd_fire && MODE == fifo_pkg::STD) dout_q <= rd_data;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  // Fall-through mode shows the head word directly; it is forced to zero while empty.
  assign dout = (MODE == fifo_pkg::FWFT) ? (empty ? '0 : rd_data) : dout_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench: a standard-mode and a fall-through instance share stimulus and a queue model.
module tb_sync_fifo_flex;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [CW-1:0] s_count, f_count;

  int errors = 0;
  int checks = 0;

  // Behavioural reference
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  bit            m_ovf, m_udf, m_armed;

  always #5 clk = ~clk;

  sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_armed = 1'b0;
  endtask

  // Applies the FIFO rules to the model for one rising edge, using pre-edge occupancy.
  task automatic model_edge(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
    int n;
    n = q.size();
    if (!m_armed) begin
      m_armed = 1'b1;
    end else if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && n == DEPTH) m_ovf = 1'b1;
      if (r && n == 0)     m_udf = 1'b1;
      if (r && n > 0)      m_dout = q.pop_front();
      if (w && n < DEPTH)  q.push_back(d);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("count",        32'(s_count), 32'(n));
    check("full",         32'(s_full),  32'(n == DEPTH));
    check("empty",        32'(s_empty), 32'(n == 0));
    check("almost_full",  32'(s_af),    32'(n >= DEPTH - 2));
    check("almost_empty", 32'(s_ae),    32'(n <= 2));
    check("overflow",     32'(s_ovf),   32'(m_ovf));
    check("underflow",    32'(s_udf),   32'(m_udf));
    check("std_dout",     32'(s_dout),  32'(m_dout));
    check("fwft_count",   32'(f_count), 32'(n));
    check("fwft_empty",   32'(f_empty), 32'(n == 0));
    check("fwft_ovf",     32'(f_ovf),   32'(m_ovf));
    check("fwft_udf",     32'(f_udf),   32'(m_udf));
    if (n > 0) check("fwft_dout", 32'(f_dout), 32'(q[0]));
  endtask

  task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din   = d;
    clr   = c;
    @(posedge clk);
    model_edge(w, r, d, c);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] d;
    model_reset();

    // Power-on reset values
    #3;
    check("rst_count",   32'(s_count), 32'd0);
    check("rst_empty",   32'(s_empty), 32'd1);
    check("rst_ae",      32'(s_ae),    32'd1);
    check("rst_full",    32'(s_full),  32'd0);
    check("rst_af",      32'(s_af),    32'd0);
    check("rst_ovf",     32'(s_ovf),   32'd0);
    check("rst_udf",     32'(s_udf),   32'd0);
    check("rst_dout",    32'(s_dout),  32'd0);
    check("rst_fdout",   32'(f_dout),  32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    idle();

    // Fall-through: a word written into an empty FIFO appears without rd_en
    step(1'b1, 1'b0, 8'hA5, 1'b0);
    check("fwft_first_dout",  32'(f_dout),  32'hA5);
    check("fwft_first_empty", 32'(f_empty), 32'd0);
    step(1'b0, 1'b1, '0, 1'b0);

    // Fill 0..15, then drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
    check("fill_full", 32'(s_full), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      check("drain_order", 32'(s_dout), 32'(i));
    end
    check("drain_empty", 32'(s_empty), 32'd1);

    // Simultaneous write and read on a full FIFO: only the read lands
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(8'h40 + i), 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    check("full_wr_rd_count", 32'(s_count), 32'd15);
    check("full_wr_rd_ovf",   32'(s_ovf),   32'd1);
    repeat (3) idle();
    check("ovf_sticky", 32'(s_ovf), 32'd1);
    repeat (DEPTH - 1) step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    check("clr_ovf", 32'(s_ovf), 32'd0);

    // Steady state at count 8 with pointers wrapping several times
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      d = DW'($urandom);
      step(1'b1, 1'b1, d, 1'b0);
      check("steady_count", 32'(s_count), 32'd8);
    end
    repeat (8) step(1'b0, 1'b1, '0, 1'b0);

    // Read while empty sets underflow; clr clears it
    step(1'b0, 1'b1, '0, 1'b0);
    check("udf_set",   32'(s_udf),   32'd1);
    check("udf_count", 32'(s_count), 32'd0);
    step(1'b0, 1'b0, '0, 1'b1);
    check("udf_clr",   32'(s_udf),   32'd0);

    // Asynchronous reset between edges at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom), 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", 32'(s_count), 32'd0);
    check("async_rst_empty", 32'(s_empty), 32'd1);
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 1'b0, '0, 1'b0);
    #1 check_all();

    // Random traffic with occasional flushes
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
           DW'($urandom), $urandom_range(0, 99) < 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
